// File: rtl/reaction_led_driver.sv
// Reaction-game round sequencer: shows a random one-hot LED target after an
// all-off gap. It scores armed hits, shrinks the reaction window on each hit,
// and ends the game after MAX_MISSES timeouts.
module reaction_led_driver #(
  parameter int unsigned WINDOW_CYCLES     = 100000000,
  parameter int unsigned MIN_WINDOW_CYCLES = 25000000,
  parameter int unsigned SHRINK_CYCLES     = 5000000,
  parameter int unsigned GAP_CYCLES        = 50000000,
  parameter int unsigned MAX_MISSES        = 3,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        hit,
  output logic [15:0] led,
  output logic        round_active,
  output logic [7:0]  score,
  output logic [3:0]  misses,
  output logic        game_over
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned LED_W  = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned SCR_W  = 8;
  localparam int unsigned MISS_W = 4;

  localparam logic [CNT_W-1:0]  WINDOW_INIT = CNT_W'(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0]  WINDOW_MIN  = CNT_W'(MIN_WINDOW_CYCLES);
  localparam logic [CNT_W-1:0]  WINDOW_STEP = CNT_W'(SHRINK_CYCLES);
  localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [MISS_W-1:0] MISS_LIMIT  = MISS_W'(MAX_MISSES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP,
    ST_SHOW,
    ST_OVER
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   counter_q, counter_d;
  logic [CNT_W-1:0]   window_q, window_d;
  logic [LED_W-1:0]   lfsr_q, lfsr_d;
  logic [IDX_W-1:0]   prev_idx_q, prev_idx_d;
  logic               armed_q, armed_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               round_active_q, round_active_d;
  logic [SCR_W-1:0]   score_q, score_d;
  logic [MISS_W-1:0]  misses_q, misses_d;
  logic               game_over_q, game_over_d;

  logic               lfsr_fb;
  logic [IDX_W-1:0]   raw_idx;
  logic [IDX_W-1:0]   next_idx;
  logic [CNT_W-1:0]   window_shrunk;
  logic [MISS_W-1:0]  misses_inc;
  logic               valid_hit;
  logic               timeout;

  // Fibonacci LFSR feedback, taps 16,14,13,11
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Target index never repeats the previous one
  assign raw_idx  = lfsr_q[IDX_W-1:0];
  assign next_idx = (raw_idx == prev_idx_q) ? raw_idx + IDX_W'(1) : raw_idx;

  // Shrunk window, clamped at the floor without unsigned underflow
  assign window_shrunk = ((window_q < WINDOW_STEP) || ((window_q - WINDOW_STEP) < WINDOW_MIN))
                         ? WINDOW_MIN : window_q - WINDOW_STEP;

  assign misses_inc = misses_q + MISS_W'(1);
  assign valid_hit  = hit & armed_q;
  assign timeout    = (counter_q == window_q - CNT_W'(1));

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    window_d   = window_q;
    lfsr_d     = {lfsr_q[LED_W-2:0], lfsr_fb};
    prev_idx_d = prev_idx_q;
    armed_d    = armed_q;
    led_d      = led_q;
    score_d    = score_q;
    misses_d   = misses_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d   = ST_GAP;
          counter_d = '0;
          window_d  = WINDOW_INIT;
          score_d   = '0;
          misses_d  = '0;
          led_d     = '0;
        end
      end
      ST_GAP: begin
        led_d = '0;
        if (counter_q == GAP_LAST) begin
          state_d    = ST_SHOW;
          counter_d  = '0;
          armed_d    = 1'b0;
          led_d      = LED_W'(1) << next_idx;
          prev_idx_d = next_idx;
        end else begin
          counter_d = counter_q + CNT_W'(1);
        end
      end
      ST_SHOW: begin
        armed_d = armed_q | ~hit;
        if (valid_hit) begin
          state_d   = ST_GAP;
          counter_d = '0;
          led_d     = '0;
          window_d  = window_shrunk;
          score_d   = (score_q == '1) ? score_q : score_q + SCR_W'(1);
        end else if (timeout) begin
          counter_d = '0;
          misses_d  = misses_inc;
          if (misses_inc == MISS_LIMIT) begin
            state_d = ST_OVER;
            led_d   = '1;
          end else begin
            state_d = ST_GAP;
            led_d   = '0;
          end
        end else begin
          counter_d = counter_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        led_d   = '0;
      end
    endcase

    round_active_d = (state_d == ST_SHOW);
    game_over_d    = (state_d == ST_OVER);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      counter_q      <= '0;
      window_q       <= WINDOW_INIT;
      lfsr_q         <= LFSR_SEED;
      prev_idx_q     <= '0;
      armed_q        <= 1'b0;
      led_q          <= '0;
      round_active_q <= 1'b0;
      score_q        <= '0;
      misses_q       <= '0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      counter_q      <= counter_d;
      window_q       <= window_d;
      lfsr_q         <= lfsr_d;
      prev_idx_q     <= prev_idx_d;
      armed_q        <= armed_d;
      led_q          <= led_d;
      round_active_q <= round_active_d;
      score_q        <= score_d;
      misses_q       <= misses_d;
      game_over_q    <= game_over_d;
    end
  end

  assign led          = led_q;
  assign round_active = round_active_q;
  assign score        = score_q;
  assign misses       = misses_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_reaction_led_driver.sv
// Bench for reaction_led_driver: directed game scenarios plus random play,
// all compared against a behavioural game model.
module tb_reaction_led_driver;

  localparam int unsigned WIN  = 20;
  localparam int unsigned MINW = 8;
  localparam int unsigned SHR  = 4;
  localparam int unsigned GAP  = 5;
  localparam int unsigned MAXM = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam int P_IDLE = 0, P_GAP = 1, P_SHOW = 2, P_OVER = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        hit;
  logic [15:0] led;
  logic        round_active;
  logic [7:0]  score;
  logic [3:0]  misses;
  logic        game_over;

  reaction_led_driver #(
    .WINDOW_CYCLES(WIN), .MIN_WINDOW_CYCLES(MINW), .SHRINK_CYCLES(SHR),
    .GAP_CYCLES(GAP), .MAX_MISSES(MAXM), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .led(led),
    .round_active(round_active), .score(score), .misses(misses), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Game model: phase, elapsed cycles in phase, window, random source
  int          m_phase;
  int          m_elapsed;
  int          m_win;
  logic [15:0] m_rng;
  int          m_prev;
  bit          m_armed;
  logic [15:0] m_led;
  int          m_score;
  int          m_miss;
  logic [15:0] last_tgt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [15:0] rng_next(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_elapsed = 0; m_win = WIN; m_rng = SEED; m_prev = 0;
    m_armed = 0; m_led = 16'h0; m_score = 0; m_miss = 0;
    last_tgt = 16'h0001;
  endtask

  task automatic new_game();
    m_phase = P_GAP; m_elapsed = 0; m_win = WIN; m_score = 0; m_miss = 0; m_led = 16'h0;
  endtask

  // One clock of game rules given the inputs seen at that edge
  task automatic model_step(input bit s, input bit h);
    int idx;
    idx = int'(m_rng) % 16;
    case (m_phase)
      P_IDLE, P_OVER: if (s) new_game();
      P_GAP: begin
        m_elapsed++;
        if (m_elapsed == GAP) begin
          if (idx == m_prev) idx = (idx + 1) % 16;
          m_prev = idx; m_led = 16'h0; m_led[idx] = 1'b1;
          m_phase = P_SHOW; m_elapsed = 0; m_armed = 0;
        end
      end
      P_SHOW: begin
        if (h && m_armed) begin
          if (m_score < 255) m_score++;
          m_win = (m_win - int'(SHR) < int'(MINW)) ? MINW : m_win - SHR;
          m_led = 16'h0; m_phase = P_GAP; m_elapsed = 0;
        end else if (m_elapsed + 1 == m_win) begin
          m_miss++; m_elapsed = 0;
          if (m_miss == MAXM) begin m_phase = P_OVER; m_led = 16'hFFFF; end
          else begin m_phase = P_GAP; m_led = 16'h0; end
        end else begin
          m_elapsed++;
          if (!h) m_armed = 1;
        end
      end
      default: m_phase = P_IDLE;
    endcase
    m_rng = rng_next(m_rng);
  endtask

  task automatic check_outputs();
    check_eq("led", led, m_led);
    check_eq("round_active", round_active, m_phase == P_SHOW);
    check_eq("score", score, m_score);
    check_eq("misses", misses, m_miss);
    check_eq("game_over", game_over, m_phase == P_OVER);
    if (m_phase == P_SHOW && m_elapsed == 0 && !m_armed) begin
      check_eq("target_onehot", $countones(led), 1);
      check_eq("target_repeat", led == last_tgt, 0);
      last_tgt = led;
    end
  endtask

  task automatic cycle(input bit s, input bit h);
    start = s; hit = h;
    @(posedge clk);
    model_step(s, h);
    #1;
    check_outputs();
  endtask

  // Run until a target is lit; stray start pulses are thrown in during GAP
  task automatic wait_show(input bit h, output int n);
    n = 0;
    while (!round_active && n < 100) begin
      cycle($urandom_range(3) == 0, h);
      n++;
    end
    check_eq("show_reached", round_active, 1);
  endtask

  // Let a target time out and report how many cycles it was lit
  task automatic measure_show(output int len);
    int n;
    wait_show(0, n);
    len = 0;
    while (round_active && len < 100) begin
      cycle(0, 0);
      len++;
    end
  endtask

  task automatic quick_hit();
    int n;
    wait_show(0, n);
    cycle(0, 0);
    cycle(0, 1);
  endtask

  initial begin
    int  n, len, guard;
    bit  sw;
    rst_n = 1'b0; start = 1'b0; hit = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_led", led, 16'h0);
    check_eq("rst_score", score, 0);
    check_eq("rst_game_over", game_over, 0);
    rst_n = 1'b1;
    cycle(0, 0);
    cycle(0, 0);

    // Start: exactly GAP dark cycles, then a lit target
    cycle(1, 0);
    wait_show(0, n);
    check_eq("gap_len", n, GAP);
    cycle(0, 0); cycle(0, 0); cycle(0, 1);
    check_eq("first_hit_score", score, 1);
    measure_show(len);
    check_eq("window_after_hit", len, 16);

    // Quick hits drive the window down to its floor
    repeat (5) quick_hit();
    check_eq("score_after_hits", score, 6);
    measure_show(len);
    check_eq("window_floor", len, MINW);
    measure_show(len);
    check_eq("window_floor2", len, MINW);
    check_eq("over_led", led, 16'hFFFF);
    check_eq("over_flag", game_over, 1);
    check_eq("over_misses", misses, MAXM);
    repeat (3) cycle(0, 1);
    check_eq("over_hit_ignored", score, 6);

    // Restart from OVER restores the full window
    cycle(1, 0);
    check_eq("restart_score", score, 0);
    check_eq("restart_go", game_over, 0);
    measure_show(len);
    check_eq("window_reset", len, WIN);

    // Hit on the last cycle of the window beats the timeout
    wait_show(0, n);
    guard = 0;
    while (m_phase == P_SHOW && m_elapsed + 1 != m_win && guard < 100) begin
      cycle(0, 0); guard++;
    end
    cycle(0, 1);
    check_eq("last_cycle_hit", score, 1);
    check_eq("last_cycle_miss", misses, 1);

    // Switch held up before the target lit cannot score
    wait_show(1, n);
    len = 0;
    while (round_active && len < 100) begin cycle(0, 1); len++; end
    check_eq("held_no_score", score, 1);
    check_eq("held_miss", misses, 2);
    wait_show(1, n);
    cycle(0, 1); cycle(0, 0); cycle(0, 1);
    check_eq("rearm_score", score, 2);

    // Many consecutive targets
    repeat (50) quick_hit();
    check_eq("score_after_50", score, 52);

    // Asynchronous reset in the middle of a lit target
    wait_show(0, n);
    cycle(0, 0);
    rst_n = 1'b0;
    #1;
    check_eq("async_led", led, 16'h0);
    check_eq("async_score", score, 0);
    check_eq("async_active", round_active, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0);

    // Random play
    sw = 1'b0;
    repeat (4000) begin
      if ($urandom_range(5) == 0) sw = ~sw;
      cycle($urandom_range(39) == 0, sw);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
